// File: rtl/array_ops_pkg.sv
// Shared types and helpers for the array stream converters.
package array_ops_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/convert_1d_to_2d_array.sv
// Splits one packed row into COLS elements; column 0 sits in the LSBs.
module convert_1d_to_2d_array #(
  parameter int BIT_WIDTH = 4,
  parameter int COLS      = 8
) (
  input  logic [COLS*BIT_WIDTH-1:0] data_i,
  output logic [BIT_WIDTH-1:0]      row_o [COLS]
);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign row_o[c] = data_i[c*BIT_WIDTH +: BIT_WIDTH];
  end

endmodule

// File: rtl/stream_1d_to_2d_array.sv
// Collects up to ROWS packed-row beats into a registered 2D frame and
// presents it on a valid/ready output, overlapping hand-off with the next fill.
module stream_1d_to_2d_array
  import array_ops_pkg::*;
#(
  parameter int BIT_WIDTH = 4,
  parameter int COLS      = 8,
  parameter int ROWS      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [COLS*BIT_WIDTH-1:0]  in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [BIT_WIDTH-1:0]       out_data [ROWS][COLS],
  output logic [$clog2(ROWS+1)-1:0]  out_rows,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int CW = cnt_w(ROWS);
  localparam int RW = $clog2(ROWS + 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        row_cnt_q, row_cnt_d;
  logic [RW-1:0]        out_rows_q, out_rows_d;
  logic [BIT_WIDTH-1:0] data_q [ROWS][COLS];
  logic [BIT_WIDTH-1:0] data_d [ROWS][COLS];
  logic [BIT_WIDTH-1:0] row_s  [COLS];
  logic                 in_fire_s;
  logic                 last_row_s;

  convert_1d_to_2d_array #(
    .BIT_WIDTH (BIT_WIDTH),
    .COLS      (COLS)
  ) u_convert (
    .data_i (in_data),
    .row_o  (row_s)
  );

  // A held frame frees its slot in the same cycle it is accepted downstream.
  assign in_ready   = (state_q == FILL) || ((state_q == HOLD) && out_ready);
  assign in_fire_s  = in_valid && in_ready;
  assign last_row_s = (row_cnt_q == CW'(ROWS - 1)) || in_last;

  assign out_valid = (state_q == HOLD);
  assign out_rows  = out_rows_q;
  assign out_data  = data_q;

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    out_rows_d = out_rows_q;
    case (state_q)
      FILL:    state_d = FILL;
      HOLD:    state_d = out_ready ? FILL : HOLD;
      default: state_d = FILL;
    endcase
    // row_cnt is 0 whenever a frame is held, so a beat taken in HOLD lands in row 0.
    if (in_fire_s) begin
      if (last_row_s) begin
        out_rows_d = RW'(row_cnt_q) + RW'(1);
        row_cnt_d  = '0;
        state_d    = HOLD;
      end else begin
        row_cnt_d = row_cnt_q + CW'(1);
      end
    end else begin
      row_cnt_d = row_cnt_q;
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (in_fire_s && (CW'(r) == row_cnt_q)) begin
          data_d[r][c] = row_s[c];
        end else if (in_fire_s && last_row_s && (r > int'(row_cnt_q))) begin
          data_d[r][c] = '0;
        end else begin
          data_d[r][c] = data_q[r][c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      row_cnt_q  <= '0;
      out_rows_q <= '0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          data_q[r][c] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      out_rows_q <= out_rows_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_stream_1d_to_2d_array.sv
// Directed and randomized checks of stream_1d_to_2d_array against a beat-queue model.
module tb_stream_1d_to_2d_array;

  localparam int BW   = 4;
  localparam int COLS = 8;
  localparam int ROWS = 4;
  localparam int RW   = $clog2(ROWS + 1);
  localparam int FW   = ROWS * COLS * BW;
  localparam int WW   = COLS * BW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [WW-1:0] in_data;
  logic          in_valid, in_last, in_ready, out_valid, out_ready;
  logic [BW-1:0] out_data [ROWS][COLS];
  logic [RW-1:0] out_rows;

  logic [WW-1:0] in_data1;
  logic          in_valid1, in_last1, in_ready1, out_valid1, out_ready1;
  logic [BW-1:0] out_data1 [1][COLS];
  logic [0:0]    out_rows1;

  stream_1d_to_2d_array #(.BIT_WIDTH(BW), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_rows(out_rows),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_1d_to_2d_array #(.BIT_WIDTH(BW), .COLS(COLS), .ROWS(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_last(in_last1),
    .in_ready(in_ready1), .out_data(out_data1), .out_rows(out_rows1),
    .out_valid(out_valid1), .out_ready(out_ready1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: accepted beats of the open frame, and the frame on offer.
  logic [WW-1:0] pend [$];
  logic [FW-1:0] m_frame = '0;
  int            m_rows = 0;
  bit            m_valid = 1'b0;
  int            beats_acc = 0;
  int            frames_out = 0;

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [FW-1:0] pack_out();
    logic [FW-1:0] v = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        v[(r*COLS + c)*BW +: BW] = out_data[r][c];
    return v;
  endfunction

  // One clock cycle with the currently driven inputs, model update and checks.
  task automatic tick();
    bit exp_rdy, fire, take;
    @(negedge clk);
    exp_rdy = !m_valid || out_ready;
    check("in_ready", FW'(in_ready), FW'(exp_rdy));
    fire = in_valid && exp_rdy;
    take = m_valid && out_ready;
    @(posedge clk);
    if (rst) begin
      pend.delete();
      m_valid = 1'b0;
      m_rows  = 0;
    end else begin
      if (take) begin
        m_valid = 1'b0;
        frames_out++;
      end
      if (fire) begin
        pend.push_back(in_data);
        beats_acc++;
        if (pend.size() == ROWS || in_last) begin
          m_frame = '0;
          foreach (pend[i]) m_frame[i*WW +: WW] = pend[i];
          m_rows  = pend.size();
          m_valid = 1'b1;
          pend.delete();
        end
      end
    end
    #1;
    check("out_valid", FW'(out_valid), FW'(m_valid));
    if (m_valid) begin
      check("out_rows", FW'(out_rows), FW'(m_rows));
      check("out_data", pack_out(), m_frame);
    end
  endtask

  task automatic beat(input logic [WW-1:0] d, input logic last, input logic ordy);
    in_valid  = 1'b1;
    in_data   = d;
    in_last   = last;
    out_ready = ordy;
    tick();
  endtask

  task automatic idle(input logic ordy);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = ordy;
    tick();
  endtask

  initial begin
    logic [FW-1:0] e;
    logic [WW-1:0] w;
    int b0, f0;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_data1 = '0; in_valid1 = 1'b0; in_last1 = 1'b0; out_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", FW'(out_valid), FW'(0));
    check("rst_out_rows", FW'(out_rows), FW'(0));
    check("rst_out_data", pack_out(), FW'(0));
    check("rst1_out_valid", FW'(out_valid1), FW'(0));
    rst = 1'b0;
    #1;
    check("rst_in_ready", FW'(in_ready), FW'(1));

    // Full frame
    beat(32'h76543210, 1'b0, 1'b1);
    beat(32'hFEDCBA98, 1'b0, 1'b1);
    beat(32'h01234567, 1'b0, 1'b1);
    check("latency_pre", FW'(out_valid), FW'(0));
    beat(32'h89ABCDEF, 1'b0, 1'b1);
    check("latency", FW'(out_valid), FW'(1));
    check("d00", FW'(out_data[0][0]), FW'(4'h0));
    check("d07", FW'(out_data[0][7]), FW'(4'h7));
    check("d10", FW'(out_data[1][0]), FW'(4'h8));
    check("d37", FW'(out_data[3][7]), FW'(4'h8));
    check("full_rows", FW'(out_rows), FW'(4));
    idle(1'b1);

    // Early last, held under backpressure
    beat(32'h11111111, 1'b0, 1'b0);
    beat(32'h22222222, 1'b1, 1'b0);
    e = '0;
    e[63:0] = 64'h22222222_11111111;
    check("early_rows", FW'(out_rows), FW'(2));
    check("early_data", pack_out(), e);
    for (int i = 0; i < 5; i++) beat(32'h33333333, 1'b0, 1'b0);
    check("bp_in_ready", FW'(in_ready), FW'(0));
    check("bp_data", pack_out(), e);
    beat(32'h33333333, 1'b0, 1'b1);
    check("bp_release_valid", FW'(out_valid), FW'(0));
    check("bp_row0", FW'(out_data[0][5]), FW'(4'h3));
    check("bp_row1", FW'(out_data[1][2]), FW'(4'h2));
    beat(32'h44444444, 1'b1, 1'b1);

    // Back-to-back frames at full rate
    b0 = beats_acc;
    f0 = frames_out;
    for (int i = 0; i < 3 * ROWS; i++) beat($urandom(), 1'b0, 1'b1);
    check("b2b_beats", FW'(beats_acc - b0), FW'(3 * ROWS));
    idle(1'b1);
    check("b2b_frames", FW'(frames_out - f0), FW'(4));

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = $urandom();
      tick();
    end

    // Mid-frame reset
    rst = 1'b1; idle(1'b1); rst = 1'b0;
    beat($urandom(), 1'b0, 1'b1);
    beat($urandom(), 1'b0, 1'b1);
    rst = 1'b1; idle(1'b1); rst = 1'b0;
    check("mid_rst_valid", FW'(out_valid), FW'(0));
    for (int i = 0; i < ROWS; i++) beat($urandom(), 1'b0, 1'b0);
    check("mid_rst_rows", FW'(out_rows), FW'(4));
    idle(1'b1);

    // ROWS=1: every accepted beat is a frame
    out_ready1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = $urandom();
      in_valid1 = 1'b1;
      in_data1  = w;
      in_last1  = i[0];
      @(posedge clk);
      #1;
      check("r1_valid", FW'(out_valid1), FW'(1));
      check("r1_rows", FW'(out_rows1), FW'(1));
      check("r1_ready", FW'(in_ready1), FW'(1));
      for (int c = 0; c < COLS; c++)
        check("r1_data", FW'(out_data1[0][c]), FW'((w >> (c * BW)) & 32'hF));
    end
    in_valid1 = 1'b0;
    @(posedge clk);
    #1;
    check("r1_drain", FW'(out_valid1), FW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
